// File: rtl/chess_layout_matrix_if.sv
// Pin bundle between the board controller and its user.
// Keys/lock are raw async pins; Layout is the 512-bit board image.
interface chess_layout_matrix_if;
  logic         LockSwitch;
  logic         KeyLeft;
  logic         KeyUp;
  logic         KeyDown;
  logic         KeyRight;
  logic [511:0] Layout;

  modport master (
    output LockSwitch, KeyLeft, KeyUp, KeyDown, KeyRight,
    input  Layout
  );

  modport slave (
    input  LockSwitch, KeyLeft, KeyUp, KeyDown, KeyRight,
    output Layout
  );
endinterface

// File: rtl/chess_layout_matrix.sv
// 8x8 chessboard state + cursor, driven by debounced keys/lock switch.
// Ports: clock, resetApp_n (async low), bus (slave: pins in, Layout out).
module chess_layout_matrix #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CURSOR_START    = 52
) (
  input  logic                  clock,
  input  logic                  resetApp_n,
  chess_layout_matrix_if.slave  bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  // bit 0 lock, 1 up, 2 down, 3 left, 4 right
  localparam logic [4:0] IN_RST = 5'b11110;

  typedef enum logic {S_IDLE, S_SEL} state_t;

  logic [4:0]    w_raw;
  logic [4:0]    r_s1;
  logic [4:0]    r_s2;
  logic [4:0]    r_deb;
  logic [4:0]    r_deb_q;
  logic [CW-1:0] r_cnt [5];

  logic [3:0]    w_press;
  logic          w_lock_rise;
  logic          w_lock_fall;

  state_t        r_state;
  state_t        w_state_nx;
  logic          w_take;
  logic          w_put;

  logic [2:0]    r_row;
  logic [2:0]    r_col;
  logic [5:0]    w_cur;
  logic [5:0]    r_src;
  logic [5:0]    r_last;
  logic          r_last_v;
  logic [3:0]    r_board [64];

  logic [1:0]    w_mark;
  logic [511:0]  w_layout;

  function automatic logic [3:0] init_sq(input int k);
    logic [2:0] back;
    int         row;
    int         col;
    row = k / 8;
    col = k % 8;
    case (col)
      0, 7:    back = 3'd3;
      1, 6:    back = 3'd5;
      2, 5:    back = 3'd4;
      3:       back = 3'd2;
      default: back = 3'd1;
    endcase
    case (row)
      0:       init_sq = {1'b0, back};
      1:       init_sq = 4'h6;
      6:       init_sq = 4'hE;
      7:       init_sq = {1'b1, back};
      default: init_sq = 4'h0;
    endcase
  endfunction

  assign w_raw = {bus.KeyRight, bus.KeyLeft, bus.KeyDown,
                  bus.KeyUp, bus.LockSwitch};

  always_ff @(posedge clock or negedge resetApp_n) begin
    if (!resetApp_n) begin
      r_s1    <= IN_RST;
      r_s2    <= IN_RST;
      r_deb   <= IN_RST;
      r_deb_q <= IN_RST;
      for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
    end else begin
      r_s1    <= w_raw;
      r_s2    <= r_s1;
      r_deb_q <= r_deb;
      for (int i = 0; i < 5; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_deb[i] <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // keys are active-low: a press is a debounced 1->0 step
  assign w_press     = r_deb_q[4:1] & ~r_deb[4:1];
  assign w_lock_rise = r_deb[0] & ~r_deb_q[0];
  assign w_lock_fall = ~r_deb[0] & r_deb_q[0];

  assign w_cur = {r_row, r_col};

  always_ff @(posedge clock or negedge resetApp_n) begin
    if (!resetApp_n) r_state <= S_IDLE;
    else             r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:
        if (w_lock_rise && r_board[w_cur][2:0] != 3'd0)
          w_state_nx = S_SEL;
      default:
        if (w_lock_fall) w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_take = 1'b0;
    w_put  = 1'b0;
    case (r_state)
      S_IDLE:
        w_take = w_lock_rise && (r_board[w_cur][2:0] != 3'd0);
      default:
        w_put = w_lock_fall && (w_cur != r_src);
    endcase
  end

  // lock actions above use w_cur before this block moves it
  always_ff @(posedge clock or negedge resetApp_n) begin
    if (!resetApp_n) begin
      r_row <= 3'(CURSOR_START / 8);
      r_col <= 3'(CURSOR_START % 8);
    end else begin
      priority case (1'b1)
        w_press[0]: if (r_row != 3'd0) r_row <= r_row - 1'b1;
        w_press[1]: if (r_row != 3'd7) r_row <= r_row + 1'b1;
        w_press[2]: if (r_col != 3'd0) r_col <= r_col - 1'b1;
        w_press[3]: if (r_col != 3'd7) r_col <= r_col + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetApp_n) begin
    if (!resetApp_n) begin
      r_src    <= '0;
      r_last   <= '0;
      r_last_v <= 1'b0;
      for (int k = 0; k < 64; k++) r_board[k] <= init_sq(k);
    end else begin
      if (w_take) begin
        r_src    <= w_cur;
        r_last_v <= 1'b0;
      end
      if (w_put) begin
        r_board[w_cur] <= r_board[r_src];
        r_board[r_src] <= 4'h0;
        r_last         <= w_cur;
        r_last_v       <= 1'b1;
      end
    end
  end

  always_comb begin
    w_layout = '0;
    w_mark   = 2'd0;
    for (int k = 0; k < 64; k++) begin
      if (r_state == S_SEL && 6'(k) == r_src)
        w_mark = 2'd2;
      else if (6'(k) == w_cur)
        w_mark = 2'd1;
      else if (r_last_v && 6'(k) == r_last)
        w_mark = 2'd3;
      else
        w_mark = 2'd0;
      w_layout[k*8 +: 8] = {2'b00, w_mark, r_board[k]};
    end
  end

  assign bus.Layout = w_layout;

endmodule

// File: tb/tb_chess_layout_matrix.sv
// Bench for chess_layout_matrix: scripted + random moves
// compared against a square-level board model.
module tb_chess_layout_matrix;

  logic clock = 1'b0;
  logic resetApp_n;
  int   errors = 0;
  int   checks = 0;

  chess_layout_matrix_if bus ();

  chess_layout_matrix #(
    .DEBOUNCE_CYCLES (4),
    .CURSOR_START    (52)
  ) dut (
    .clock      (clock),
    .resetApp_n (resetApp_n),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  int m_board [64];
  int m_cur;
  bit m_sel;
  int m_src;
  bit m_lastv;
  int m_last;
  bit m_lock;

  logic [511:0] lay;
  logic [511:0] exp_l;

  task automatic model_reset();
    int back [8] = '{3, 5, 4, 2, 1, 4, 5, 3};
    for (int k = 0; k < 64; k++) begin
      if (k < 8)        m_board[k] = back[k];
      else if (k < 16)  m_board[k] = 6;
      else if (k < 48)  m_board[k] = 0;
      else if (k < 56)  m_board[k] = 14;
      else              m_board[k] = 8 + back[k-56];
    end
    m_cur = 52; m_sel = 0; m_src = 0;
    m_lastv = 0; m_last = 0; m_lock = 0;
  endtask

  function automatic logic [511:0] exp_layout();
    logic [511:0] v;
    int mk;
    v = '0;
    for (int k = 0; k < 64; k++) begin
      if (m_sel && k == m_src)         mk = 2;
      else if (k == m_cur)             mk = 1;
      else if (m_lastv && k == m_last) mk = 3;
      else                             mk = 0;
      v[k*8 +: 8] = 8'(mk * 16 + m_board[k]);
    end
    return v;
  endfunction

  task automatic settle();
    repeat (14) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic lock_event(input bit rise);
    if (rise) begin
      if (!m_sel && (m_board[m_cur] % 8) != 0) begin
        m_sel = 1; m_src = m_cur; m_lastv = 0;
      end
    end else if (m_sel) begin
      if (m_cur != m_src) begin
        m_board[m_cur] = m_board[m_src];
        m_board[m_src] = 0;
        m_last = m_cur; m_lastv = 1;
      end
      m_sel = 0;
    end
    m_lock = rise;
  endtask

  // press bits: 0 up, 1 down, 2 left, 3 right
  task automatic drive(input logic [3:0] press, input bit tog);
    int r, c;
    bus.KeyUp    = ~press[0];
    bus.KeyDown  = ~press[1];
    bus.KeyLeft  = ~press[2];
    bus.KeyRight = ~press[3];
    if (tog) bus.LockSwitch = ~bus.LockSwitch;
    settle();
    if (tog) lock_event(!m_lock);
    r = m_cur / 8; c = m_cur % 8;
    if (press[0])      r = (r > 0) ? r - 1 : r;
    else if (press[1]) r = (r < 7) ? r + 1 : r;
    else if (press[2]) c = (c > 0) ? c - 1 : c;
    else if (press[3]) c = (c < 7) ? c + 1 : c;
    m_cur = r * 8 + c;
    bus.KeyUp = 1; bus.KeyDown = 1; bus.KeyLeft = 1; bus.KeyRight = 1;
    settle();
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetApp_n = 1'b0;
    bus.KeyUp = 1; bus.KeyDown = 1; bus.KeyLeft = 1; bus.KeyRight = 1;
    bus.LockSwitch = 0;
    repeat (3) @(negedge clock);
    resetApp_n = 1'b1;
    model_reset();
    settle();
  endtask

  task automatic test_reset();
    if (bus.Layout[52*8 +: 8] !== 8'h1E) begin
      errors++; $display("FAIL reset_b52 got %h want 1e", bus.Layout[52*8 +: 8]);
    end
    checks++;
    if (bus.Layout[0 +: 8] !== 8'h03) begin
      errors++; $display("FAIL reset_b0 got %h want 03", bus.Layout[0 +: 8]);
    end
    checks++;
    if (bus.Layout[60*8 +: 8] !== 8'h09) begin
      errors++; $display("FAIL reset_b60 got %h want 09", bus.Layout[60*8 +: 8]);
    end
    checks++;
    if (bus.Layout[35*8 +: 8] !== 8'h00) begin
      errors++; $display("FAIL reset_b35 got %h want 00", bus.Layout[35*8 +: 8]);
    end
    checks++;
    lay = bus.Layout; exp_l = exp_layout();
    if (lay !== exp_l) begin
      errors++; $display("FAIL reset_board got %h want %h", lay, exp_l);
    end
    checks++;
  endtask

  task automatic test_hold();
    bus.KeyUp = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    m_cur = 44;
    if (bus.Layout[44*8 +: 8] !== 8'h10) begin
      errors++; $display("FAIL hold_b44 got %h want 10", bus.Layout[44*8 +: 8]);
    end
    checks++;
    if (bus.Layout[52*8 +: 8] !== 8'h0E) begin
      errors++; $display("FAIL hold_b52 got %h want 0e", bus.Layout[52*8 +: 8]);
    end
    checks++;
    repeat (30) @(negedge clock);
    bus.KeyUp = 1'b1;
    settle();
    lay = bus.Layout; exp_l = exp_layout();
    if (lay !== exp_l) begin
      errors++; $display("FAIL hold_no_repeat got %h want %h", lay, exp_l);
    end
    checks++;
  endtask

  task automatic test_glitch();
    bus.KeyUp = 1'b0;
    repeat (2) @(negedge clock);
    bus.KeyUp = 1'b1;
    settle();
    lay = bus.Layout; exp_l = exp_layout();
    if (lay !== exp_l) begin
      errors++; $display("FAIL glitch got %h want %h", lay, exp_l);
    end
    checks++;
  endtask

  task automatic test_clamp();
    drive(4'b0010, 0);
    for (int i = 0; i < 5; i++) drive(4'b1000, 0);
    if (bus.Layout[55*8 +: 8] !== 8'h1E) begin
      errors++; $display("FAIL clamp_b55 got %h want 1e", bus.Layout[55*8 +: 8]);
    end
    checks++;
    lay = bus.Layout; exp_l = exp_layout();
    if (lay !== exp_l) begin
      errors++; $display("FAIL clamp_board got %h want %h", lay, exp_l);
    end
    checks++;
  endtask

  task automatic test_select_move();
    for (int i = 0; i < 3; i++) drive(4'b0100, 0);
    drive(4'b0000, 1);
    if (bus.Layout[52*8 +: 8] !== 8'h2E) begin
      errors++; $display("FAIL sel_b52 got %h want 2e", bus.Layout[52*8 +: 8]);
    end
    checks++;
    drive(4'b0001, 0);
    drive(4'b0001, 0);
    if (bus.Layout[36*8 +: 8] !== 8'h10) begin
      errors++; $display("FAIL sel_b36 got %h want 10", bus.Layout[36*8 +: 8]);
    end
    checks++;
    drive(4'b0000, 1);
    if (bus.Layout[36*8 +: 8] !== 8'h1E) begin
      errors++; $display("FAIL drop_b36 got %h want 1e", bus.Layout[36*8 +: 8]);
    end
    checks++;
    if (bus.Layout[52*8 +: 8] !== 8'h00) begin
      errors++; $display("FAIL drop_b52 got %h want 00", bus.Layout[52*8 +: 8]);
    end
    checks++;
    drive(4'b0100, 0);
    if (bus.Layout[36*8 +: 8] !== 8'h3E) begin
      errors++; $display("FAIL last_b36 got %h want 3e", bus.Layout[36*8 +: 8]);
    end
    checks++;
  endtask

  task automatic test_empty_lock();
    drive(4'b0000, 1);
    if (bus.Layout[35*8 +: 8] !== 8'h10) begin
      errors++; $display("FAIL empty_b35 got %h want 10", bus.Layout[35*8 +: 8]);
    end
    checks++;
    drive(4'b1000, 0);
    drive(4'b0000, 1);
    lay = bus.Layout; exp_l = exp_layout();
    if (lay !== exp_l) begin
      errors++; $display("FAIL empty_idle got %h want %h", lay, exp_l);
    end
    checks++;
  endtask

  task automatic test_cancel();
    drive(4'b0000, 1);
    drive(4'b0000, 1);
    lay = bus.Layout; exp_l = exp_layout();
    if (lay !== exp_l) begin
      errors++; $display("FAIL cancel got %h want %h", lay, exp_l);
    end
    checks++;
  endtask

  task automatic test_capture();
    drive(4'b0000, 1);
    for (int i = 0; i < 3; i++) drive(4'b0001, 0);
    drive(4'b0000, 1);
    if (bus.Layout[12*8 +: 8] !== 8'h1E) begin
      errors++; $display("FAIL cap_b12 got %h want 1e", bus.Layout[12*8 +: 8]);
    end
    checks++;
    if (bus.Layout[36*8 +: 8] !== 8'h00) begin
      errors++; $display("FAIL cap_b36 got %h want 00", bus.Layout[36*8 +: 8]);
    end
    checks++;
    lay = bus.Layout; exp_l = exp_layout();
    if (lay !== exp_l) begin
      errors++; $display("FAIL cap_board got %h want %h", lay, exp_l);
    end
    checks++;
  endtask

  task automatic test_random();
    logic [3:0] p;
    bit t;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) p = 4'($urandom_range(0, 15));
      else p = 4'b0001 << $urandom_range(0, 3);
      t = ($urandom_range(0, 2) == 0);
      drive(p, t);
      lay = bus.Layout; exp_l = exp_layout();
      if (lay !== exp_l) begin
        errors++; $display("FAIL rand_%0d got %h want %h", i, lay, exp_l);
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid_move();
    do_reset();
    drive(4'b0000, 1);
    drive(4'b0001, 0);
    if (bus.Layout[52*8 +: 8] !== 8'h2E) begin
      errors++; $display("FAIL mid_sel got %h want 2e", bus.Layout[52*8 +: 8]);
    end
    checks++;
    @(negedge clock);
    resetApp_n = 1'b0;
    #1;
    model_reset();
    lay = bus.Layout; exp_l = exp_layout();
    if (lay !== exp_l) begin
      errors++; $display("FAIL mid_reset got %h want %h", lay, exp_l);
    end
    checks++;
    repeat (2) @(negedge clock);
    resetApp_n = 1'b1;
    settle();
    lock_event(1);
    if (bus.Layout[52*8 +: 8] !== 8'h2E) begin
      errors++; $display("FAIL lock_thru_rst got %h want 2e", bus.Layout[52*8 +: 8]);
    end
    checks++;
    drive(4'b0001, 0);
    drive(4'b0000, 1);
    lay = bus.Layout; exp_l = exp_layout();
    if (lay !== exp_l) begin
      errors++; $display("FAIL post_rst_move got %h want %h", lay, exp_l);
    end
    checks++;
  endtask

  initial begin
    resetApp_n = 1'b0;
    bus.LockSwitch = 0;
    bus.KeyUp = 1; bus.KeyDown = 1; bus.KeyLeft = 1; bus.KeyRight = 1;
    do_reset();
    test_reset();
    test_hold();
    test_glitch();
    test_clamp();
    test_select_move();
    test_empty_lock();
    test_cancel();
    test_capture();
    test_random();
    test_reset_mid_move();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
